// File: rtl/generador_pkg.sv
// rtl/generador_pkg.sv - shared command/state types and sensor phase patterns
package generador_pkg;

  typedef enum logic [1:0] {
    CMD_ENTRY  = 2'b00,
    CMD_EXIT   = 2'b01,
    CMD_REV_S1 = 2'b10,
    CMD_REV_S2 = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_PH4  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // {S1,S2} per phase, PH1 in the top two bits down to PH4 in the bottom two
  localparam logic [7:0] ENTRY_SEQ  = 8'b10_11_01_00;
  localparam logic [7:0] EXIT_SEQ   = 8'b01_11_10_00;
  localparam logic [7:0] REV_S1_SEQ = 8'b10_00_00_00;
  localparam logic [7:0] REV_S2_SEQ = 8'b01_00_00_00;

  function automatic logic [1:0] phase_pattern(input cmd_t cmd, input state_t st);
    logic [7:0] seq;
    logic [1:0] pat;
    seq = 8'b0;
    pat = 2'b00;
    case (cmd)
      CMD_ENTRY:  seq = ENTRY_SEQ;
      CMD_EXIT:   seq = EXIT_SEQ;
      CMD_REV_S1: seq = REV_S1_SEQ;
      CMD_REV_S2: seq = REV_S2_SEQ;
      default:    seq = 8'b0;
    endcase
    case (st)
      ST_PH1:  pat = seq[7:6];
      ST_PH2:  pat = seq[5:4];
      ST_PH3:  pat = seq[3:2];
      ST_PH4:  pat = seq[1:0];
      default: pat = 2'b00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// rtl/bcd_sat_counter.sv - two-digit BCD up/down counter saturating at 00 and 99
module bcd_sat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] unidades,
  output logic [3:0] decenas
);

  logic at_max;
  logic at_min;

  assign at_max = (decenas == 4'd9) && (unidades == 4'd9);
  assign at_min = (decenas == 4'd0) && (unidades == 4'd0);

  // clr wins over a coincident inc/dec
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unidades <= 4'd0;
      decenas  <= 4'd0;
    end else if (clr) begin
      unidades <= 4'd0;
      decenas  <= 4'd0;
    end else if (inc && !at_max) begin
      if (unidades == 4'd9) begin
        unidades <= 4'd0;
        decenas  <= decenas + 4'd1;
      end else begin
        unidades <= unidades + 4'd1;
      end
    end else if (dec && !at_min) begin
      if (unidades == 4'd0) begin
        unidades <= 4'd9;
        decenas  <= decenas - 4'd1;
      end else begin
        unidades <= unidades - 4'd1;
      end
    end
  end

endmodule

// File: rtl/generador_sensores.sv
// rtl/generador_sensores.sv - barrier sensor sequence generator with expected car count mirror
module generador_sensores
  import generador_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset_btn_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_type,
  output logic       cmd_ready,
  input  logic       clr_exp,
  output logic       S1,
  output logic       S2,
  output logic       busy,
  output logic       done,
  output logic [3:0] exp_unidades,
  output logic [3:0] exp_decenas
);

  localparam logic [15:0] TIMER_RELOAD = 16'(PHASE_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  cmd_t        cmd_reg;
  cmd_t        next_cmd;
  logic [15:0] timer;
  logic        phase_end;
  logic        accept;
  logic        is_rev;
  logic        next_is_phase;
  logic        cnt_inc;
  logic        cnt_dec;

  assign phase_end     = (timer == 16'd0);
  assign accept        = (state == ST_IDLE) && cmd_valid;
  assign next_cmd      = accept ? cmd_t'(cmd_type) : cmd_reg;
  assign is_rev        = (cmd_reg == CMD_REV_S1) || (cmd_reg == CMD_REV_S2);
  assign next_is_phase = (next_state == ST_PH1) || (next_state == ST_PH2) ||
                         (next_state == ST_PH3) || (next_state == ST_PH4);

  // S1/S2 are registered from the next state so the first pattern lands on the accepting edge
  always_ff @(posedge clk or negedge reset_btn_n) begin
    if (!reset_btn_n) begin
      state   <= ST_IDLE;
      cmd_reg <= CMD_ENTRY;
      timer   <= 16'd0;
      S1      <= 1'b0;
      S2      <= 1'b0;
    end else begin
      state   <= next_state;
      cmd_reg <= next_cmd;
      {S1, S2} <= phase_pattern(next_cmd, next_state);
      if ((next_state != state) && next_is_phase) begin
        timer <= TIMER_RELOAD;
      end else if (!phase_end) begin
        timer <= timer - 16'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (cmd_valid) next_state = ST_PH1;
      ST_PH1:  if (phase_end) next_state = ST_PH2;
      ST_PH2:  if (phase_end) next_state = is_rev ? ST_DONE : ST_PH3;
      ST_PH3:  if (phase_end) next_state = ST_PH4;
      ST_PH4:  if (phase_end) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    cnt_inc   = (state == ST_PH4) && phase_end && (cmd_reg == CMD_ENTRY);
    cnt_dec   = (state == ST_PH4) && phase_end && (cmd_reg == CMD_EXIT);
  end

  bcd_sat_counter u_exp_count (
    .clk      (clk),
    .rst_n    (reset_btn_n),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .clr      (clr_exp),
    .unidades (exp_unidades),
    .decenas  (exp_decenas)
  );

endmodule

// File: tb/tb_generador_sensores.sv
// tb/tb_generador_sensores.sv - directed self-checking bench for generador_sensores
module tb_generador_sensores;

  logic       clk = 1'b0;
  logic       reset_btn_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'b00;
  logic       cmd_ready;
  logic       clr_exp = 1'b0;
  logic       S1, S2;
  logic       busy, done;
  logic [3:0] exp_unidades, exp_decenas;

  int vectors = 0;
  int errors  = 0;

  generador_sensores #(.PHASE_CYCLES(4)) dut (
    .clk          (clk),
    .reset_btn_n  (reset_btn_n),
    .cmd_valid    (cmd_valid),
    .cmd_type     (cmd_type),
    .cmd_ready    (cmd_ready),
    .clr_exp      (clr_exp),
    .S1           (S1),
    .S2           (S2),
    .busy         (busy),
    .done         (done),
    .exp_unidades (exp_unidades),
    .exp_decenas  (exp_decenas)
  );

  always #5 clk = ~clk;

  // Offers a command, waits for acceptance and the return to IDLE; ends on a negedge in IDLE
  task automatic run_cmd(input logic [1:0] t, output int dones, output bit timeout);
    int cyc;
    dones   = 0;
    timeout = 1'b0;
    cyc     = 0;
    cmd_valid = 1'b1;
    cmd_type  = t;
    while (!cmd_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!cmd_ready && cyc < 200) begin
      if (done) dones++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) timeout = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_exp = 1'b1;
    @(negedge clk);
    clr_exp = 1'b0;
  endtask

  task automatic test_reset();
    reset_btn_n = 1'b0;
    #17;
    vectors++;
    if ({S1, S2, cmd_ready, busy, done} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_outputs: got S1S2/ready/busy/done=%b, want 00100", {S1, S2, cmd_ready, busy, done});
    end
    vectors++;
    if ({exp_decenas, exp_unidades} !== 8'h00) begin
      errors++;
      $display("FAIL reset_exp: got %h, want 00", {exp_decenas, exp_unidades});
    end
    @(negedge clk);
    reset_btn_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_entry();
    logic [1:0] want_s;
    logic       want_busy, want_done, want_rdy;
    logic [7:0] pats;
    pats = 8'b10_11_01_00;
    cmd_valid = 1'b1;
    cmd_type  = 2'b00;
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      if (k <= 16) begin
        case ((k - 1) / 4)
          0: want_s = pats[7:6];
          1: want_s = pats[5:4];
          2: want_s = pats[3:2];
          default: want_s = pats[1:0];
        endcase
        {want_busy, want_done, want_rdy} = 3'b100;
      end else if (k == 17) begin
        want_s = 2'b00;
        {want_busy, want_done, want_rdy} = 3'b110;
      end else begin
        want_s = 2'b00;
        {want_busy, want_done, want_rdy} = 3'b001;
      end
      vectors++;
      if ({S1, S2, busy, done, cmd_ready} !== {want_s, want_busy, want_done, want_rdy}) begin
        errors++;
        $display("FAIL entry_clock_%0d: got S1S2/busy/done/ready=%b, want %b",
                 k, {S1, S2, busy, done, cmd_ready}, {want_s, want_busy, want_done, want_rdy});
      end
      if (k == 16 || k == 17) begin
        vectors++;
        if ({exp_decenas, exp_unidades} !== ((k == 16) ? 8'h00 : 8'h01)) begin
          errors++;
          $display("FAIL entry_exp_clock_%0d: got %h, want %h", k, {exp_decenas, exp_unidades},
                   (k == 16) ? 8'h00 : 8'h01);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int d, total;
    bit to, any_to;
    total = 0;
    any_to = 1'b0;
    pulse_clr();
    vectors++;
    if ({exp_decenas, exp_unidades} !== 8'h00) begin
      errors++;
      $display("FAIL clr_exp: got %h, want 00", {exp_decenas, exp_unidades});
    end
    for (int i = 0; i < 20; i++) begin
      run_cmd(2'b00, d, to);
      total += d;
      any_to |= to;
    end
    vectors++;
    if ({exp_decenas, exp_unidades} !== 8'h20) begin
      errors++;
      $display("FAIL b2b_after_entries: got %h, want 20", {exp_decenas, exp_unidades});
    end
    for (int i = 0; i < 5; i++) begin
      run_cmd(2'b01, d, to);
      total += d;
      any_to |= to;
    end
    vectors++;
    if ({exp_decenas, exp_unidades} !== 8'h15) begin
      errors++;
      $display("FAIL b2b_exp: got %h, want 15", {exp_decenas, exp_unidades});
    end
    vectors++;
    if (total !== 25) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, want 25", total);
    end
    vectors++;
    if (any_to) begin
      errors++;
      $display("FAIL b2b_timeout: sequence did not return to idle");
    end
  endtask

  task automatic test_rev(input logic [1:0] t);
    int s1_cnt, s2_cnt, d, cyc;
    s1_cnt = 0;
    s2_cnt = 0;
    d = 0;
    cyc = 0;
    cmd_valid = 1'b1;
    cmd_type  = t;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!cmd_ready && cyc < 100) begin
      if (S1) s1_cnt++;
      if (S2) s2_cnt++;
      if (done) d++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL rev%0d_length: got %0d busy clocks, want 9", t, cyc);
    end
    vectors++;
    if ({s1_cnt, s2_cnt} !== ((t == 2'b10) ? {32'd4, 32'd0} : {32'd0, 32'd4})) begin
      errors++;
      $display("FAIL rev%0d_sensors: got S1 high %0d, S2 high %0d", t, s1_cnt, s2_cnt);
    end
    vectors++;
    if (d !== 1 || {exp_decenas, exp_unidades} !== 8'h15) begin
      errors++;
      $display("FAIL rev%0d_exp: got done=%0d exp=%h, want done=1 exp=15", t, d, {exp_decenas, exp_unidades});
    end
  endtask

  task automatic test_saturation();
    int d;
    bit to, any_to;
    any_to = 1'b0;
    pulse_clr();
    for (int i = 0; i < 100; i++) begin
      run_cmd(2'b00, d, to);
      any_to |= to;
    end
    vectors++;
    if ({exp_decenas, exp_unidades} !== 8'h99 || any_to) begin
      errors++;
      $display("FAIL sat_high: got %h timeout=%0d, want 99", {exp_decenas, exp_unidades}, any_to);
    end
    run_cmd(2'b01, d, to);
    vectors++;
    if ({exp_decenas, exp_unidades} !== 8'h98) begin
      errors++;
      $display("FAIL sat_exit_from_99: got %h, want 98", {exp_decenas, exp_unidades});
    end
    pulse_clr();
    run_cmd(2'b01, d, to);
    vectors++;
    if ({exp_decenas, exp_unidades} !== 8'h00 || d !== 1) begin
      errors++;
      $display("FAIL sat_low: got %h done=%0d, want 00 done=1", {exp_decenas, exp_unidades}, d);
    end
    run_cmd(2'b00, d, to);
    // second ENTRY with clr_exp held on the edge that enters DONE
    cmd_valid = 1'b1;
    cmd_type  = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (15) @(negedge clk);
    clr_exp = 1'b1;
    @(negedge clk);
    clr_exp = 1'b0;
    vectors++;
    if (done !== 1'b1 || {exp_decenas, exp_unidades} !== 8'h00) begin
      errors++;
      $display("FAIL clr_coincident: got done=%b exp=%h, want done=1 exp=00", done, {exp_decenas, exp_unidades});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d;
    d = 0;
    cmd_valid = 1'b1;
    cmd_type  = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if ({S1, S2} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_in_ph2: got S1S2=%b, want 11", {S1, S2});
    end
    #2;
    reset_btn_n = 1'b0;
    #1;
    vectors++;
    if ({S1, S2, cmd_ready, busy, done} !== 5'b00100 || {exp_decenas, exp_unidades} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_immediate: got S1S2/ready/busy/done=%b exp=%h, want 00100 exp=00",
               {S1, S2, cmd_ready, busy, done}, {exp_decenas, exp_unidades});
    end
    repeat (2) @(negedge clk);
    reset_btn_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || S1 || S2 || !cmd_ready) d++;
    end
    vectors++;
    if (d !== 0 || {exp_decenas, exp_unidades} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_after: %0d active clocks exp=%h, want 0 and 00", d, {exp_decenas, exp_unidades});
    end
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_back_to_back();
    test_rev(2'b10);
    test_rev(2'b11);
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/generador_sensores.md
GENERADOR_SENSORES -- requirements
Module: generador_sensores

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 200; clocks each sensor pattern phase is held; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-003 SHALL have port reset_btn_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit; a command is offered.
REQ-005 SHALL have port cmd_type, input, 2 bits; 00 ENTRY, 01 EXIT, 10 REV_S1, 11 REV_S2.
REQ-006 SHALL have port cmd_ready, output, 1 bit; the generator can accept a command.
REQ-007 SHALL have port clr_exp, input, 1 bit; synchronous clear of the expected-count mirror.
REQ-008 SHALL have ports S1 and S2, outputs, 1 bit each; emulated barrier sensors driving the car counter inputs.
REQ-009 SHALL have port busy, output, 1 bit; a sequence is in progress.
REQ-010 SHALL have port done, output, 1 bit; one-cycle pulse when a sequence completes.
REQ-011 SHALL have ports exp_unidades and exp_decenas, outputs, 4 bits each; expected BCD car count, 0..99.

Function
REQ-012 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1, and capture cmd_type on that edge.
REQ-013 SHALL register S1 and S2 so the first phase pattern appears on the accepting edge.
REQ-014 SHALL use FSM states IDLE, PH1, PH2, PH3, PH4, DONE; IDLE is the only state with cmd_ready=1.
REQ-015 SHALL hold each phase for exactly PHASE_CYCLES clocks, using a phase timer reloaded on every phase entry.
REQ-016 SHALL drive ENTRY as S1S2 = 10, 11, 01, 00 in PH1..PH4.
REQ-017 SHALL drive EXIT as S1S2 = 01, 11, 10, 00 in PH1..PH4.
REQ-018 SHALL drive REV_S1 as 10 then 00 and REV_S2 as 01 then 00 in PH1..PH2, going from PH2 directly to DONE.
REQ-019 SHALL spend exactly one cycle in DONE with done=1, S1=S2=0, cmd_ready=0, then return to IDLE.
REQ-020 SHALL keep busy=1 in PH1..PH4 and DONE, and 0 in IDLE.
REQ-021 SHALL update the expected count on the edge entering DONE: ENTRY +1 saturating at 99; EXIT -1 saturating at 0; REV_* unchanged.
REQ-022 SHALL carry the BCD count 09 -> 10 on increment and borrow 10 -> 09 on decrement; digits SHALL never exceed 9.
REQ-023 SHALL give clr_exp priority when it coincides with a count update: the result is 00.
REQ-024 SHALL ignore cmd_valid while cmd_ready=0; the command is neither queued nor dropped silently (it stays offered).
REQ-025 SHALL take minimum command spacing of 4*PHASE_CYCLES+2 clocks for ENTRY/EXIT and 2*PHASE_CYCLES+2 for REV_*.

Reset
REQ-026 SHALL, while reset_btn_n=0, force state IDLE, S1=S2=0, busy=0, done=0, cmd_ready=1, expected count 00 and phase timer 0, regardless of clk.
REQ-027 SHALL, on reset mid-sequence, abort the sequence with no count update and no done pulse.

Structure
REQ-028 SHALL use a shared package generador_pkg holding the cmd_type enum, the FSM state enum and the per-command phase pattern constants.
REQ-029 SHALL implement the saturating BCD up/down mirror as sub-module bcd_sat_counter (inc, dec, clr, unidades, decenas).

Verification (PHASE_CYCLES=4)
REQ-030 SHALL cover: reset asserted -> S1=S2=0, cmd_ready=1, busy=0, exp=00.
REQ-031 SHALL cover: one ENTRY -> S1S2 10,11,01,00 for 4 clocks each, done pulse at clock 17, exp=01, cmd_ready back at clock 18.
REQ-032 SHALL cover: 20 ENTRY then 5 EXIT back-to-back -> exp=15, 25 done pulses.
REQ-033 SHALL cover: REV_S1 then REV_S2 -> S1 high 4 clocks with S2 never high (then vice versa), exp unchanged at 15.
REQ-034 SHALL cover: 100 ENTRY from 00 -> exp=99, then EXIT -> 98; EXIT at 00 -> stays 00; clr_exp coincident with ENTRY done -> 00.
REQ-035 SHALL cover: reset_btn_n pulsed low during PH2 of ENTRY -> S1=S2=0 immediately, no done, exp=00, cmd_ready=1 after release.
